// File: rtl/lsu_mem_ctrl.sv
// LSU execute/memory stage: effective-address generation, alignment check,
// single outstanding valid/ready memory access and load-data formatting.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_load,
  input  logic              zero_ext,
  input  logic              is_nop,
  input  logic [1:0]        size,
  input  logic [4:0]        rd,
  input  logic [11:0]       imm,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       rs2_data,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign_exc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              r_state;
  logic                r_is_load;
  logic                r_zext;
  logic [1:0]          r_size;
  logic [1:0]          r_off;
  logic [4:0]          r_rd;
  logic                r_req_valid;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_wb_valid;
  logic [4:0]          r_wb_rd;
  logic [31:0]         r_wb_data;
  logic                r_exc;

  logic [31:0]         w_addr;
  logic                w_misalign;
  logic [31:0]         w_wdata;
  logic [3:0]          w_wstrb;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_ldata;

  // Effective address (wraps modulo 2^32) and alignment check
  always_comb begin
    w_addr     = rs1_data + {{20{imm[11]}}, imm};
    w_misalign = (size == 2'b11) ||
                 ((size == 2'b01) && w_addr[0]) ||
                 ((size == 2'b10) && (w_addr[1:0] != 2'b00));
  end

  // Store lane replication and byte enables; loads drive no strobes
  always_comb begin
    w_wdata = rs2_data;
    w_wstrb = '0;
    case (size)
      2'b00: begin
        w_wdata = {4{rs2_data[7:0]}};
        w_wstrb = 4'b0001 << w_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{rs2_data[15:0]}};
        w_wstrb = 4'b0011 << w_addr[1:0];
      end
      default: begin
        w_wdata = rs2_data;
        w_wstrb = 4'b1111;
      end
    endcase
    if (is_load) w_wstrb = '0;
  end

  // Load lane selection and sign/zero extension from the latched op
  always_comb begin
    w_byte  = mem_resp_rdata[{r_off, 3'b000} +: 8];
    w_half  = mem_resp_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_ldata = r_zext ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ldata = r_zext ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ldata = mem_resp_rdata;
    endcase
  end

  // Access FSM with registered request, writeback and exception outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_load   <= 1'b0;
      r_zext      <= 1'b0;
      r_size      <= '0;
      r_off       <= '0;
      r_rd        <= '0;
      r_req_valid <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_exc       <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_exc      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!is_nop) begin
            if (w_misalign) begin
              r_exc <= 1'b1;
            end else begin
              r_is_load   <= is_load;
              r_zext      <= zero_ext;
              r_size      <= size;
              r_off       <= w_addr[1:0];
              r_rd        <= rd;
              r_req_valid <= 1'b1;
              r_we        <= ~is_load;
              r_addr      <= {w_addr[ADDR_W-1:2], 2'b00};
              r_wdata     <= w_wdata;
              r_wstrb     <= w_wstrb;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            r_state <= S_IDLE;
            if (r_is_load) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= w_ldata;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall         = (r_state != S_IDLE);
  assign mem_req_valid = r_req_valid;
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wstrb = r_wstrb;
  assign wb_valid      = r_wb_valid;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign misalign_exc  = r_exc;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
LSU execute/memory stage that consumes the decoded load/store fields from the LSU ID/EX pipeline register and performs the access. It computes the effective address, issues one request on a valid/ready memory port and waits for the response. It formats load data for writeback and drives `stall` back to the ID/EX register while an access is outstanding.

Parameters:
ADDR_W, 32, memory request address width; the effective address is truncated to ADDR_W LSBs.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
is_load  in  1  1=load, 0=store
zero_ext  in  1  load zero-extend (1) / sign-extend (0)
is_nop  in  1  slot holds no LSU op
size  in  2  00=byte, 01=half, 10=word, 11=illegal
rd  in  5  load destination register
imm  in  12  signed offset
rs1_data  in  32  base register value
rs2_data  in  32  store data
stall  out  1  hold ID/EX register
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=write
mem_req_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_req_wdata  out  32  lane-replicated store data
mem_req_wstrb  out  4  byte enables
mem_resp_valid  in  1  response / write-ack, one-cycle pulse
mem_resp_rdata  in  32  read word
wb_valid  out  1  load result valid, one-cycle pulse
wb_rd  out  5  load destination
wb_data  out  32  extended load result
misalign_exc  out  1  one-cycle pulse on misaligned or illegal-size op

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high; it is sampled only on the rising edge of clk.
- State machine: IDLE, REQ, WAIT.
- `stall` = (state != IDLE), combinational from state.
- IDLE, !is_nop:
  - Compute addr = rs1_data + sign_extend(imm); wrap modulo 2^32.
  - Misaligned if size=01 and addr[0], or size=10 and addr[1:0]!=0, or size=11.
  - If misaligned: pulse misalign_exc next cycle, issue no request, stay IDLE.
  - Otherwise: latch is_load, zero_ext, size, rd, addr[1:0], wdata, wstrb; go to REQ.
- IDLE, is_nop: no action.
- REQ:
  - mem_req_valid=1. Addr, we, wdata and wstrb stay stable until mem_req_ready.
  - On valid&&ready, go to WAIT.
- WAIT:
  - On mem_resp_valid, go to IDLE.
  - If the latched op is a load, register wb_valid=1, wb_rd and wb_data for exactly one cycle, on the cycle after the response.
  - A store produces no wb_valid.
- mem_resp_valid in IDLE or REQ is ignored. The response is never accepted in the same cycle as the request handshake.
- Store wdata and wstrb:
  - byte: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - half: wdata = {2{rs2[15:0]}}, wstrb = 0011 << addr[1:0].
  - word: wdata = rs2, wstrb = 1111.
  - Loads drive wstrb = 0000 and we = 0.
- Load data: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]. Extend per zero_ext. Word ignores zero_ext.
- rd=0 loads still pulse wb_valid; the register file discards x0.
- Minimum latency with ready and response immediate:
  - cycle 0: capture
  - cycle 1: REQ handshake
  - cycle 2: response
  - cycle 3: wb_valid
- Throughput: one access per 3 cycles minimum.
- Reset values: state=IDLE, stall=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wstrb=0, wb_valid=0, wb_rd=0, wb_data=0, misalign_exc=0.
- Reset mid-operation: the outstanding request is dropped and state returns to IDLE. The memory side must not deliver a late response after reset.
- While `stall`=1 the inputs are held by ID/EX and are not re-sampled. The op presented in the cycle stall falls is captured in that same cycle.

Test Plan:
- Load word, rs1=0x1000, imm=0x004, ready=1, resp rdata=0xDEADBEEF -> req addr=0x1004, we=0; wb_valid at cycle 3 with wb_data=0xDEADBEEF; stall=1 in cycles 1-2.
- Load byte signed, addr=0x2003, rdata=0x80FF_FF7F -> wb_data=0xFFFFFF80. Same access with zero_ext=1 -> 0x00000080.
- Store half, rs1=0x3000, imm=0xFFE (-2), rs2=0x1234ABCD -> addr=0x2FFC, wstrb=1100, wdata=0xABCDABCD, we=1; no wb_valid.
- Misaligned word load at addr=0x1002, and size=11 -> misalign_exc pulse, no mem_req_valid, stall stays 0.
- Load with ready low for 3 cycles, then response delayed 2 cycles -> addr/wdata stable throughout; stall held; exactly one wb_valid; spurious resp_valid during REQ ignored.
- rst asserted while in WAIT -> next cycle all outputs at reset values, state IDLE; a following load completes normally.
